// File: rtl/icache_refill_ctrl_if.sv
// Refill-controller bus: cache miss input, lower-memory request/return channel,
// and the cache write port. The master side is the refill controller.
interface icache_refill_ctrl_if #(
    parameter int SIZE_PC     = 32,
    parameter int CACHE_WIDTH = 256,
    parameter int BEAT_WIDTH  = 64
);
    logic                   miss_i;
    logic [SIZE_PC-1:0]     missAddr_i;
    logic                   memReq_o;
    logic [SIZE_PC-1:0]     memAddr_o;
    logic                   memGnt_i;
    logic                   memDataValid_i;
    logic [BEAT_WIDTH-1:0]  memData_i;
    logic                   wrEnable_o;
    logic [SIZE_PC-1:0]     wrAddr_o;
    logic [CACHE_WIDTH-1:0] instBlock_o;
    logic                   busy_o;
    logic [15:0]            refillCount_o;

    modport master (
        input  miss_i, missAddr_i, memGnt_i, memDataValid_i, memData_i,
        output memReq_o, memAddr_o, wrEnable_o, wrAddr_o, instBlock_o,
               busy_o, refillCount_o
    );

    modport slave (
        output miss_i, missAddr_i, memGnt_i, memDataValid_i, memData_i,
        input  memReq_o, memAddr_o, wrEnable_o, wrAddr_o, instBlock_o,
               busy_o, refillCount_o
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// L1 I-cache miss sequencer: one block-aligned refill request, beat assembly,
// and a single-cycle cache write of the completed block.
module icache_refill_ctrl #(
    parameter int SIZE_PC     = 32,
    parameter int CACHE_WIDTH = 256,
    parameter int BEAT_WIDTH  = 64,
    parameter int OFFSET_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    icache_refill_ctrl_if.master bus
);
    localparam int BEATS = CACHE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_beat;
    logic [SIZE_PC-1:0]     r_blk_addr;
    logic [SIZE_PC-1:0]     r_wr_addr;
    logic [CACHE_WIDTH-1:0] r_fill;
    logic [CACHE_WIDTH-1:0] r_inst_block;
    logic [15:0]            r_refill_cnt;

    logic                   w_beat_fire;
    logic                   w_last_beat;
    logic [SIZE_PC-1:0]     w_blk_addr;
    logic [CACHE_WIDTH-1:0] w_fill_next;

    // Mask rather than slice so the discarded offset bits are still consumed.
    assign w_blk_addr  = bus.missAddr_i & ~((SIZE_PC'(1) << OFFSET_BITS) - SIZE_PC'(1));
    assign w_beat_fire = (r_state == S_FILL) && bus.memDataValid_i;
    assign w_last_beat = (r_beat == CNT_W'(BEATS - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_fill_next = r_fill;
        w_fill_next[r_beat*BEAT_WIDTH +: BEAT_WIDTH] = bus.memData_i;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.miss_i) w_state_next = S_REQ;
            S_REQ:   if (bus.memGnt_i) w_state_next = S_FILL;
            S_FILL:  if (w_beat_fire && w_last_beat) w_state_next = S_WRITE;
            S_WRITE: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the block buffers are plain flops, not a RAM, so resetting them is cheap and lets an abandoned refill leave no stale data.
        if (!reset) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_blk_addr   <= '0;
            r_wr_addr    <= '0;
            r_fill       <= '0;
            r_inst_block <= '0;
            r_refill_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            r_state <= w_state_next;
            if (r_state == S_IDLE && bus.miss_i) begin
                r_blk_addr <= w_blk_addr;
                r_beat     <= '0;
            end
            if (w_beat_fire) begin
                r_fill <= w_fill_next;
                r_beat <= r_beat + 1'b1;
            end
            // The final beat goes straight into the output block, ready for WRITE.
            if (w_beat_fire && w_last_beat) begin
                r_inst_block <= w_fill_next;
                r_wr_addr    <= r_blk_addr;
            end
            if (r_state == S_WRITE && r_refill_cnt != 16'hFFFF) begin
                r_refill_cnt <= r_refill_cnt + 1'b1;
            end
        end
    end

    assign bus.memReq_o      = (r_state == S_REQ);
    assign bus.memAddr_o     = r_blk_addr;
    assign bus.wrEnable_o    = (r_state == S_WRITE);
    assign bus.wrAddr_o      = r_wr_addr;
    assign bus.instBlock_o   = r_inst_block;
    assign bus.busy_o        = (r_state != S_IDLE);
    assign bus.refillCount_o = r_refill_cnt;
endmodule
